// File: rtl/traffic_pkg.sv
// Shared types for the traffic controller: phase enum, lamp encoding and
// the phase-to-lamp mapping used for the approach that owns the phase.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2
    } state_t;

    // Per-approach lamp word, one-hot {r, y, g}
    localparam int unsigned LAMP_W = 3;
    typedef logic [LAMP_W-1:0] lamp_t;

    localparam lamp_t LAMP_R = 3'b100;
    localparam lamp_t LAMP_Y = 3'b010;
    localparam lamp_t LAMP_G = 3'b001;

    // Lamp shown by the owning approach in a given phase
    function automatic lamp_t phase_lamp(input state_t s);
        case (s)
            GREEN:   return LAMP_G;
            YELLOW:  return LAMP_Y;
            default: return LAMP_R;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of req searching base+1, base+2, ...
// modulo N (base itself is examined last).
// Ports: req (request vector), base (last owner), grant_idx (winner),
//        grant_valid (any request present). Purely combinational.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned AW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [AW-1:0] base,
    output logic [AW-1:0] grant_idx,
    output logic          grant_valid
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(base) + k) % N;
            if (!grant_valid && req[AW'(idx)]) begin
                grant_valid = 1'b1;
                grant_idx   = AW'(idx);
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-approach traffic light controller with demand-driven round-robin
// service, min/max green extension, yellow and all-red clearance.
// Ports: Clk, reset (sync, active-high), tick (timebase enable),
//        car[N_APP] (vehicle sensors), R/Y/G[N_APP] (registered lamps),
//        active (approach owning the phase), ST (phase-change pulse).
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int unsigned N_APP  = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned T_GMIN = 4,
    parameter int unsigned T_GMAX = 10,
    parameter int unsigned T_YEL  = 2,
    parameter int unsigned T_AR   = 1,
    localparam int unsigned AW    = $clog2(N_APP)
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [N_APP-1:0] car,
    output logic [N_APP-1:0] R,
    output logic [N_APP-1:0] Y,
    output logic [N_APP-1:0] G,
    output logic [AW-1:0]    active,
    output logic             ST
);

    localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

    // Parameter sanity, rejected at elaboration
    if (N_APP < 2 || N_APP > 16) begin : g_bad_napp
        $error("traffic_ctrl_n: N_APP must be in 2..16");
    end
    if (T_GMIN < 1 || T_GMAX < 1 || T_YEL < 1 || T_AR < 1) begin : g_bad_tmin
        $error("traffic_ctrl_n: all phase times must be at least 1");
    end
    if (T_GMAX < T_GMIN) begin : g_bad_gmax
        $error("traffic_ctrl_n: T_GMAX must not be below T_GMIN");
    end
    if (64'(T_GMIN) > CNT_MAX || 64'(T_GMAX) > CNT_MAX ||
        64'(T_YEL) > CNT_MAX || 64'(T_AR) > CNT_MAX) begin : g_bad_width
        $error("traffic_ctrl_n: phase time exceeds timer range");
    end

    // Exit thresholds expressed as the last timer value of each interval
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GMIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(T_GMAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_AR - 1);

    function automatic logic [N_APP-1:0] onehot(input logic [AW-1:0] i);
        return N_APP'(1) << i;
    endfunction

    state_t             state, state_n;
    logic [AW-1:0]      active_n;
    logic [AW-1:0]      nxt, nxt_n;
    logic [CNT_W-1:0]   timer, timer_n;
    logic [N_APP-1:0]   dem, dem_n;
    logic [N_APP-1:0]   r_n, y_n, g_n;
    logic               st_n;
    logic [N_APP-1:0]   act_mask;
    logic [N_APP-1:0]   others;
    logic [AW-1:0]      pick_idx;
    logic               pick_valid;

    assign act_mask = onehot(active);
    assign others   = dem & ~act_mask;

    // Next approach to serve; grant_valid doubles as "another approach waits"
    rr_pick #(
        .N  (N_APP),
        .AW (AW)
    ) u_rr_pick (
        .req         (others),
        .base        (active),
        .grant_idx   (pick_idx),
        .grant_valid (pick_valid)
    );

    // Phase sequencing, demand capture and lamp decode
    always_comb begin
        lamp_t lamp;
        state_n  = state;
        active_n = active;
        nxt_n    = nxt;
        timer_n  = timer;
        st_n     = 1'b0;
        r_n      = '0;
        y_n      = '0;
        g_n      = '0;
        lamp     = LAMP_R;

        // The approach currently on green cannot register demand for itself
        dem_n = dem | (car & ~((state == GREEN) ? act_mask : '0));

        if (tick) begin
            timer_n = (timer == '1) ? timer : timer + 1'b1;
            case (state)
                GREEN: begin
                    if (pick_valid &&
                        ((timer >= GMIN_LAST && !car[active]) || timer >= GMAX_LAST)) begin
                        state_n = YELLOW;
                        nxt_n   = pick_idx;
                    end
                end
                YELLOW: begin
                    if (timer == YEL_LAST) state_n = ALLRED;
                end
                ALLRED: begin
                    if (timer == AR_LAST) begin
                        state_n  = GREEN;
                        active_n = nxt;
                        // Clear beats a simultaneous car on the entering approach
                        dem_n    = dem_n & ~onehot(nxt);
                    end
                end
                default: state_n = GREEN;
            endcase
            if (state_n != state) begin
                timer_n = '0;
                st_n    = 1'b1;
            end
        end

        for (int unsigned i = 0; i < N_APP; i++) begin
            lamp   = (AW'(i) == active_n) ? phase_lamp(state_n) : LAMP_R;
            r_n[i] = lamp[2];
            y_n[i] = lamp[1];
            g_n[i] = lamp[0];
        end
    end

    // State and registered outputs
    always_ff @(posedge Clk) begin
        if (reset) begin
            state  <= GREEN;
            active <= '0;
            nxt    <= '0;
            timer  <= '0;
            dem    <= '0;
            G      <= N_APP'(1);
            R      <= ~N_APP'(1);
            Y      <= '0;
            ST     <= 1'b1;
        end else begin
            state  <= state_n;
            active <= active_n;
            nxt    <= nxt_n;
            timer  <= timer_n;
            dem    <= dem_n;
            G      <= g_n;
            R      <= r_n;
            Y      <= y_n;
            ST     <= st_n;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Bench for traffic_ctrl_n at default parameters: directed scenarios with
// literal expectations plus a per-cycle comparison against a phase model.
module tb_traffic_ctrl_n;

    localparam int NA     = 4;
    localparam int GMIN   = 4;
    localparam int GMAX   = 10;
    localparam int YEL    = 2;
    localparam int AR     = 1;
    localparam int TMAX   = 255;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b1;
    logic [NA-1:0] car = '0;
    logic [NA-1:0] R, Y, G;
    logic [1:0]    active;
    logic          ST;

    int errors = 0;
    int checks = 0;
    int st_cnt = 0;

    traffic_ctrl_n dut (
        .Clk    (Clk),
        .reset  (reset),
        .tick   (tick),
        .car    (car),
        .R      (R),
        .Y      (Y),
        .G      (G),
        .active (active),
        .ST     (ST)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 green, 1 yellow, 2 all-red; ticks counts ticks spent in phase
    int      m_phase = 0, m_act = 0, m_next = 0, m_ticks = 0;
    bit [NA-1:0] m_dem = '0;
    bit      m_st = 1'b0, m_valid = 1'b0;

    always @(posedge Clk) begin : model
        bit [NA-1:0] nd;
        bit          chg, other;
        int          j;
        if (reset) begin
            m_phase = 0; m_act = 0; m_next = 0; m_ticks = 0;
            m_dem = '0; m_st = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            nd = m_dem;
            for (int i = 0; i < NA; i++)
                if (car[i] && !(m_phase == 0 && i == m_act)) nd[i] = 1'b1;
            chg = 1'b0;
            if (tick) begin
                if (m_phase == 0) begin
                    other = 1'b0;
                    for (int i = 0; i < NA; i++)
                        if (i != m_act && m_dem[i]) other = 1'b1;
                    if (other && ((m_ticks + 1 >= GMIN && !car[m_act]) || m_ticks + 1 >= GMAX)) begin
                        for (int k = NA; k >= 1; k--) begin
                            j = (m_act + k) % NA;
                            if (m_dem[j] && j != m_act) m_next = j;
                        end
                        m_phase = 1; chg = 1'b1;
                    end
                end else if (m_phase == 1) begin
                    if (m_ticks + 1 == YEL) begin m_phase = 2; chg = 1'b1; end
                end else begin
                    if (m_ticks + 1 == AR) begin
                        m_phase = 0; m_act = m_next; nd[m_next] = 1'b0; chg = 1'b1;
                    end
                end
                if (chg) m_ticks = 0;
                else if (m_ticks < TMAX) m_ticks++;
            end
            m_dem = nd;
            m_st  = chg;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge
    always @(negedge Clk) begin : compare
        logic [NA-1:0] er, ey, eg;
        if (m_valid) begin
            er = '1; ey = '0; eg = '0;
            if (m_phase == 0) begin eg[m_act] = 1'b1; er[m_act] = 1'b0; end
            if (m_phase == 1) begin ey[m_act] = 1'b1; er[m_act] = 1'b0; end
            chk("model_R", 32'(R), 32'(er));
            chk("model_Y", 32'(Y), 32'(ey));
            chk("model_G", 32'(G), 32'(eg));
            chk("model_active", 32'(active), 32'(m_act));
            chk("model_ST", 32'(ST), 32'(m_st));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic steps(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            if (ST) st_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        steps(1);
        reset = 1'b0;
        st_cnt = 0;
    endtask

    initial begin
        car = '0; tick = 1'b1;

        // Reset state and idle hold
        do_reset();
        chk("rst_G", 32'(G), 32'h1);
        chk("rst_R", 32'(R), 32'he);
        chk("rst_Y", 32'(Y), 32'h0);
        chk("rst_active", 32'(active), 32'h0);
        chk("rst_ST", 32'(ST), 32'h1);
        steps(50);
        chk("idle_st_count", 32'(st_cnt), 32'h0);
        chk("idle_G", 32'(G), 32'h1);

        // Single car[2] pulse: 4 green, 2 yellow, 1 all-red, then green 2
        do_reset();
        car = 4'b0100; steps(1); car = '0;
        st_cnt = 0;
        steps(2);
        chk("p2_green_end", 32'(G), 32'h1);
        steps(1);
        chk("p2_yellow", 32'(Y), 32'h1);
        chk("p2_yellow_st", 32'(ST), 32'h1);
        steps(2);
        chk("p2_allred", 32'(R), 32'hf);
        steps(1);
        chk("p2_green2", 32'(G), 32'h4);
        chk("p2_active", 32'(active), 32'h2);
        chk("p2_st_count", 32'(st_cnt), 32'h3);

        // car[0] held extends green to the maximum
        do_reset();
        car = 4'b0011; steps(1); car = 4'b0001;
        steps(8);
        chk("gmax_still_green", 32'(G), 32'h1);
        steps(1);
        chk("gmax_yellow", 32'(Y), 32'h1);
        steps(3);
        chk("gmax_green1", 32'(G), 32'h2);
        chk("gmax_active1", 32'(active), 32'h1);
        car = '0;
        steps(30);

        // Wrap-around order from active=2 with demand on 1 and 3
        do_reset();
        car = 4'b0100; steps(1); car = '0;
        steps(3);
        car = 4'b1010; steps(1); car = '0;
        steps(2);
        chk("rr_active2", 32'(active), 32'h2);
        steps(7);
        chk("rr_active3", 32'(active), 32'h3);
        chk("rr_G3", 32'(G), 32'h8);
        steps(7);
        chk("rr_active1", 32'(active), 32'h1);
        chk("rr_G1", 32'(G), 32'h2);
        steps(20);
        chk("rr_dem_cleared", 32'(active), 32'h1);

        // Freeze mid-yellow with tick low
        do_reset();
        car = 4'b0100; steps(1); car = '0;
        steps(4);
        chk("frz_yellow", 32'(Y), 32'h1);
        tick = 1'b0;
        car = 4'b1000; steps(1); car = '0;
        steps(19);
        chk("frz_held_Y", 32'(Y), 32'h1);
        chk("frz_no_st", 32'(ST), 32'h0);
        tick = 1'b1;
        steps(1);
        chk("frz_resume_allred", 32'(R), 32'hf);
        steps(1);
        chk("frz_green2", 32'(G), 32'h4);
        steps(20);

        // Reset during yellow of approach 1
        do_reset();
        car = 4'b0010; steps(1); car = '0;
        steps(6);
        chk("ry_green1", 32'(G), 32'h2);
        car = 4'b1001; steps(1); car = '0;
        steps(3);
        chk("ry_yellow1", 32'(Y), 32'h2);
        reset = 1'b1; steps(1); reset = 1'b0;
        chk("ry_G", 32'(G), 32'h1);
        chk("ry_Y", 32'(Y), 32'h0);
        chk("ry_R", 32'(R), 32'he);
        chk("ry_active", 32'(active), 32'h0);
        chk("ry_ST", 32'(ST), 32'h1);
        steps(12);
        chk("ry_dem_cleared", 32'(active), 32'h0);
        chk("ry_hold_G", 32'(G), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_ctrl_n.md
TRAFFIC_CTRL_N -- requirements
Module: traffic_ctrl_n

Interface
REQ-001 Parameter N_APP, default 4, number of approaches (2..16).
REQ-002 Parameter CNT_W, default 8, phase timer width in bits.
REQ-003 Parameter T_GMIN, default 4, minimum green length in ticks.
REQ-004 Parameter T_GMAX, default 10, maximum extended green length in ticks.
REQ-005 Parameter T_YEL, default 2, yellow length in ticks.
REQ-006 Parameter T_AR, default 1, all-red clearance length in ticks.
REQ-007 Clk  in  1  clock; all state changes on the rising edge.
REQ-008 reset  in  1  reset, synchronous, active-high.
REQ-009 tick  in  1  timebase enable; timers advance only on edges with tick=1.
REQ-010 car  in  N_APP  per-approach vehicle sensor, level or single-cycle pulse.
REQ-011 R, Y, G  out  N_APP each  registered lamp drives, one bit per approach.
REQ-012 active  out  $clog2(N_APP)  index of the approach owning the current phase.
REQ-013 ST  out  1  one-cycle pulse on every phase change and on reset.

Function
REQ-014 The FSM SHALL have exactly three states: GREEN, YELLOW, ALLRED.
REQ-015 In GREEN, G[active]=1; in YELLOW, Y[active]=1; all other lamp bits are 0 except R, which is 1 for every approach not lit G or Y.
REQ-016 Each approach SHALL show exactly one lamp at all times; in ALLRED, R is all ones.
REQ-017 The demand register dem[i] SHALL be set by car[i]=1 and cleared on the edge where approach i enters GREEN; clear wins on a simultaneous set.
REQ-018 A car on the active approach during GREEN SHALL NOT set dem[active].
REQ-019 The timer SHALL reset to 0 on every phase entry, increment on tick edges, and saturate at 2^CNT_W-1.
REQ-020 Exit GREEN to YELLOW on a tick edge when other = |(dem without active) is 1 and either (timer>=T_GMIN-1 and car[active]=0) or timer>=T_GMAX-1.
REQ-021 With other=0, GREEN SHALL hold indefinitely regardless of timer value.
REQ-022 On GREEN exit, next SHALL be latched as the first i with dem[i]=1, searching active+1, active+2, ... modulo N_APP (round-robin with wrap).
REQ-023 Exit YELLOW to ALLRED on a tick edge with timer==T_YEL-1; exit ALLRED to GREEN on a tick edge with timer==T_AR-1, setting active to next.
REQ-024 A new dem bit arriving during YELLOW or ALLRED SHALL NOT alter the latched next.
REQ-025 With tick=0, state, timer and lamps SHALL be frozen; dem still captures car.
REQ-026 ST SHALL be 1 for exactly the cycle after each transition edge, and 0 otherwise.
REQ-027 Elaboration SHALL fail if any T_* is less than 1, if T_GMAX < T_GMIN, or if any T_* exceeds 2^CNT_W-1.

Reset
REQ-028 reset SHALL force state GREEN, active=0, timer=0, dem=0, G=...0001, R=...1110, Y=0, ST=1; this takes priority over all other inputs.
REQ-029 Reset asserted mid-phase, including YELLOW or ALLRED, SHALL take effect on the next edge with no intermediate lamp state.

Structure
REQ-030 Package traffic_pkg SHALL hold the state enum (GREEN, YELLOW, ALLRED) and the lamp-encoding constants.
REQ-031 Round-robin next-selection SHALL be a combinational sub-module rr_pick(req, base, grant_idx, grant_valid).

Verification
Conditions for all scenarios: default parameters, tick=1 every cycle.
REQ-032 No cars for 50 cycles after reset -> G[0]=1 throughout; ST pulses once, at reset only.
REQ-033 Single-cycle car[2] pulse with car[0]=0 -> G[0] for 4 cycles, Y[0] for 2, all-red for 1, then G[2] with active=2; ST pulses 3 times.
REQ-034 car[0] held at 1 and car[1] pulsed -> G[0] lasts 10 cycles, then Y[0]; G[1] follows after 3 further cycles.
REQ-035 active=2, dem={1,3} -> served order is 3 then 1 (wrap-around); dem cleared for each on entry.
REQ-036 tick=0 for 20 cycles mid-YELLOW -> lamps unchanged; phase resumes with the remaining yellow count on tick=1.
REQ-037 reset asserted during Y[1] -> next cycle G[0]=1, active=0, dem=0, ST=1.
